// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-side (ps2_keyboard) and CPU-side (event FIFO read) signals of the key event controller.
interface ps2_key_event_ctrl_if;
   logic [7:0]  keydata;
   logic        ready;
   logic        overflow;
   logic        nextdata_n;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        rd_valid;

   modport master (
      output keydata, ready, overflow, rd_en,
      input  nextdata_n, rd_data, rd_valid
   );

   modport slave (
      input  keydata, ready, overflow, rd_en,
      output nextdata_n, rd_data, rd_valid
   );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Pops bytes from ps2_keyboard, folds E0/F0 prefixes into key events, tracks modifiers
// and queues events in a show-ahead FIFO for the CPU keyboard register.
//
// state  | meaning
// S_IDLE | waiting for ready; keydata latched on exit
// S_POP  | nextdata_n low for one cycle; latched byte decoded
// S_GAP  | nextdata_n high, ready ignored while receiver updates
module ps2_key_event_ctrl #(
   parameter int DEPTH       = 16,
   parameter bit DROP_REPEAT = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  clrn_i,
   ps2_key_event_ctrl_if.slave   bus,
   input  logic                  err_clr_i,
   output logic                  shift_o,
   output logic                  ctrl_o,
   output logic                  caps_o,
   output logic [7:0]            key_count_o,
   output logic                  err_o
);

   localparam int        AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

   state_t state_q, state_d;
   logic   latch_en;

   logic [7:0]  byte_q, byte_d;
   logic        ext_q, ext_d, brk_q, brk_d;
   logic        lshift_q, lshift_d, rshift_q, rshift_d;
   logic        ctrl_q, ctrl_d, caps_q, caps_d;
   logic [8:0]  last_make_q, last_make_d;
   logic        last_vld_q, last_vld_d;
   logic [7:0]  count_q, count_d;
   logic        err_q, err_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0] last_rd_q, last_rd_d;
   logic [15:0] mem_q [DEPTH];

   logic        is_pop, evt_done, evt_make, repeat_hit, push, pop, wr_ok, drop;
   logic        empty, full;
   logic [15:0] evt_word;

   always_ff @(posedge clk_i) begin
      if (!clrn_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.ready) state_d = S_POP;
         S_POP:   state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.nextdata_n = (state_q != S_POP);
      latch_en       = (state_q == S_IDLE) && bus.ready;
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign is_pop     = (state_q == S_POP);
   assign evt_done   = is_pop && (byte_q != 8'hE0) && (byte_q != 8'hF0);
   assign evt_make   = evt_done && !brk_q;
   assign repeat_hit = DROP_REPEAT && last_vld_q && (last_make_q == {ext_q, byte_q});
   assign push       = evt_done && !(evt_make && repeat_hit);
   assign pop        = bus.rd_en && !empty;
   assign wr_ok      = push && (!full || pop);
   assign drop       = push && full && !pop;
   assign evt_word   = {brk_q, ext_q, 6'b0, byte_q};

   always_comb begin
      byte_d      = byte_q;
      ext_d       = ext_q;
      brk_d       = brk_q;
      lshift_d    = lshift_q;
      rshift_d    = rshift_q;
      ctrl_d      = ctrl_q;
      caps_d      = caps_q;
      last_make_d = last_make_q;
      last_vld_d  = last_vld_q;
      count_d     = count_q;
      err_d       = err_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      last_rd_d   = last_rd_q;

      if (latch_en) byte_d = bus.keydata;

      if (is_pop) begin
         if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (byte_q == 8'h12) lshift_d = !brk_q;
            if (byte_q == 8'h59) rshift_d = !brk_q;
            if (byte_q == 8'h14) ctrl_d   = !brk_q;
            if (byte_q == 8'h58 && brk_q) caps_d = !caps_q;
            // last_make only remembers makes that actually landed in the FIFO
            if (brk_q) begin
               last_vld_d = 1'b0;
            end else if (wr_ok) begin
               last_vld_d  = 1'b1;
               last_make_d = {ext_q, byte_q};
            end
         end
      end

      if (wr_ok && evt_make) count_d = count_q + 8'd1;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         last_rd_d = mem_q[rd_ptr_q[AW-1:0]];
      end

      if (err_clr_i)              err_d = 1'b0;
      if (bus.overflow || drop)   err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!clrn_i) begin
         byte_q      <= 8'h00;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         ctrl_q      <= 1'b0;
         caps_q      <= 1'b0;
         last_make_q <= 9'h000;
         last_vld_q  <= 1'b0;
         count_q     <= 8'h00;
         err_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         last_rd_q   <= 16'h0000;
      end else begin
         byte_q      <= byte_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         ctrl_q      <= ctrl_d;
         caps_q      <= caps_d;
         last_make_q <= last_make_d;
         last_vld_q  <= last_vld_d;
         count_q     <= count_d;
         err_q       <= err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         last_rd_q   <= last_rd_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= evt_word;
   end

   assign bus.rd_valid = !empty;
   assign bus.rd_data  = empty ? last_rd_q : mem_q[rd_ptr_q[AW-1:0]];
   assign shift_o      = lshift_q || rshift_q;
   assign ctrl_o       = ctrl_q;
   assign caps_o       = caps_q;
   assign key_count_o  = count_q;
   assign err_o        = err_q;

endmodule
